fifo_word_packer: RTL and testbench
===================================

// Module: fifo_word_packer
// PURPOSE
//  Read-side drain stage for the dual-clock fifo, clocked in its read (fast) domain.
//  Pops DATA_WIDTH entries, packs PACK_COUNT of them into one word, first entry in the LSB lane.
//  Presents each word on a valid/ready output. A flush request emits a partial word.
//  Accounts for the fifo's one-cycle registered read latency: read_data is valid the cycle after a pop.
// PARAMETERS
//  DATA_WIDTH  8  width of one fifo entry
//  PACK_COUNT  4  entries per output word; must be >= 2
//  Derived (localparam): OUT_WIDTH = DATA_WIDTH*PACK_COUNT, CNT_WIDTH = $clog2(PACK_COUNT)+1
// PORTS
//  clk               in   1           read-domain clock (the fifo's fast_clk)
//  reset_n           in   1           asynchronous, active-low reset
//  fifo_read_enable  out  1           pop request to the fifo
//  fifo_read_data    in   DATA_WIDTH  fifo read_data, valid the cycle after a pop
//  fifo_empty        in   1           fifo empty_flag
//  flush             in   1           single-cycle pulse: emit the accumulated partial word
//  out_data          out  OUT_WIDTH   packed word; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH]
//  out_bytes         out  CNT_WIDTH   valid lanes in out_data, 1..PACK_COUNT
//  out_valid         out  1           out_data/out_bytes valid
//  out_ready         in   1           consumer accepts the word when out_valid && out_ready
//  busy              out  1           data held anywhere in the block
// BEHAVIOUR
//  Reset: reset_n low clears all state. All outputs are 0: out_valid, out_data, out_bytes,
//   and fifo_read_enable (forced low). Internal state: lane_cnt=0, pop_pend=0, flush_pend=0.
//  Pop: fifo_read_enable is combinational:
//   = !fifo_empty && !flush_pend && (lane_cnt + pop_pend < PACK_COUNT).
//   pop_pend <= fifo_read_enable every cycle.
//  Capture: when pop_pend=1, fifo_read_data is written into lane[lane_cnt] and lane_cnt increments.
//   Back-to-back pops are allowed, giving one entry per cycle.
//  Full word: when lane_cnt==PACK_COUNT, pop_pend is necessarily 0.
//   The word loads into the output register when out_valid==0 or out_ready==1.
//   On load: out_bytes=PACK_COUNT, out_valid=1, lane_cnt<=0.
//   While the load is blocked, no pops are issued.
//  Output hold: while out_valid && !out_ready, out_data and out_bytes are stable.
//   out_valid clears on a handshake unless a new word loads in the same cycle.
//   Back-to-back words are possible.
//  Flush:
//   - A flush pulse sets flush_pend. Flush while flush_pend=1 is ignored.
//   - flush_pend blocks new pops. An in-flight pop (pop_pend=1) still captures.
//   - Once pop_pend==0, with the output register free:
//     - lane_cnt>0: load the partial word. Unused lanes are 0. out_bytes=lane_cnt.
//       Then lane_cnt<=0 and flush_pend<=0.
//     - lane_cnt==0: flush_pend<=0, no word is emitted.
//   - Flush when lane_cnt==PACK_COUNT: the full word goes first. The next cycle sees lane_cnt==0,
//     so flush_pend clears with no extra word.
//  busy = (lane_cnt!=0) | pop_pend | out_valid | flush_pend.
//  Reset mid-operation: accumulated lanes, the in-flight pop and any held word are discarded.
//   The entry popped in the cycle before reset is lost. That is accepted; the upstream fifo
//   is reset together with this block.
//  fifo_empty is trusted as-is. The fifo ignores pops while empty, so a stale empty deassertion
//   only costs a cycle, never data.
// TESTING
//  1. out_ready=1; fifo holds 0x11,0x22,0x33,0x44 -> pops on 4 consecutive cycles;
//     out_data=0x44332211, out_bytes=4, out_valid for 1 cycle.
//  2. out_ready=0 for 12 cycles; fifo holds 0x01..0x08.
//     -> Word 0x04030201 held stable.
//     -> Second word assembled in lanes; fifo_read_enable low after 8 pops.
//     -> On release: 0x04030201, then 0x08070605 on the next cycle; no loss.
//  3. 0xA1,0xA2,0xA3, then fifo empty; flush pulse -> out_data=0x00A3A2A1, out_bytes=3; busy falls.
//  4. Flush in the same cycle a pop is issued (lane_cnt=1, entry 0xB2 in flight)
//     -> captures 0xB2; emits 0x0000B2B1, out_bytes=2.
//  5. Flush with lane_cnt=0 and pop_pend=0 -> no out_valid; flush_pend clears within 1 cycle.
//  6. reset_n low mid-word (lane_cnt=2, out_valid=1) -> all outputs 0 asynchronously.
//     After release, the next 4 entries form a clean word.

Source files
------------

// File: rtl/fifo_word_packer.sv
// Read-side drain stage of the dual-clock fifo: pops entries, packs PACK_COUNT of them
// (first entry in lane 0) into one word on a valid/ready output; flush emits a partial word.
module fifo_word_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK_COUNT = 4
) (
  input  logic                               clk,
  input  logic                               reset_n,
  output logic                               fifo_read_enable,
  input  logic [DATA_WIDTH-1:0]              fifo_read_data,
  input  logic                               fifo_empty,
  input  logic                               flush,
  output logic [DATA_WIDTH*PACK_COUNT-1:0]   out_data,
  output logic [$clog2(PACK_COUNT):0]        out_bytes,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               busy
);

  localparam int OUT_WIDTH = DATA_WIDTH * PACK_COUNT;
  localparam int CNT_WIDTH = $clog2(PACK_COUNT) + 1;
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(PACK_COUNT);

  logic [CNT_WIDTH-1:0] lane_cnt_q, lane_cnt_d;
  logic                 pop_pend_q;
  logic                 flush_pend_q, flush_pend_d;
  logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic [CNT_WIDTH-1:0] out_bytes_q, out_bytes_d;
  logic                 out_valid_q, out_valid_d;

  logic [OUT_WIDTH-1:0] packed_word;
  logic [CNT_WIDTH-1:0] occupancy;
  logic                 pop_req;
  logic                 out_free;
  logic                 lanes_full;
  logic                 flush_drain;
  logic                 load_word;

  // Lanes already filled plus the entry still in flight from the fifo's read register.
  assign occupancy   = lane_cnt_q + CNT_WIDTH'(pop_pend_q);
  assign pop_req     = !fifo_empty && !flush_pend_q && (occupancy < FULL_CNT);
  assign fifo_read_enable = pop_req && reset_n;

  assign out_free    = !out_valid_q || out_ready;
  assign lanes_full  = (lane_cnt_q == FULL_CNT);
  // A full word goes out first; the pending flush resolves once the lanes are empty.
  assign flush_drain = flush_pend_q && !pop_pend_q && !lanes_full && out_free;
  assign load_word   = (lanes_full && out_free) || (flush_drain && (lane_cnt_q != '0));

  generate
    for (genvar gi = 0; gi < PACK_COUNT; gi++) begin : g_lane
      logic [DATA_WIDTH-1:0] lane_q;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          lane_q <= '0;
        end else if (pop_pend_q && (lane_cnt_q == CNT_WIDTH'(gi))) begin
          lane_q <= fifo_read_data;
        end
      end

      // Lanes beyond the fill level read as zero so partial words carry no stale data.
      assign packed_word[gi*DATA_WIDTH +: DATA_WIDTH] =
        (CNT_WIDTH'(gi) < lane_cnt_q) ? lane_q : '0;
    end
  endgenerate

  always_comb begin
    lane_cnt_d   = lane_cnt_q;
    flush_pend_d = flush_pend_q;
    out_data_d   = out_data_q;
    out_bytes_d  = out_bytes_q;
    out_valid_d  = out_valid_q;

    if (load_word) begin
      lane_cnt_d = '0;
    end else if (pop_pend_q) begin
      lane_cnt_d = lane_cnt_q + 1'b1;
    end

    if (flush_pend_q) begin
      if (flush_drain) begin
        flush_pend_d = 1'b0;
      end
    end else if (flush) begin
      flush_pend_d = 1'b1;
    end

    if (load_word) begin
      out_data_d  = packed_word;
      out_bytes_d = lane_cnt_q;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lane_cnt_q   <= '0;
      pop_pend_q   <= 1'b0;
      flush_pend_q <= 1'b0;
      out_data_q   <= '0;
      out_bytes_q  <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      lane_cnt_q   <= lane_cnt_d;
      pop_pend_q   <= pop_req;
      flush_pend_q <= flush_pend_d;
      out_data_q   <= out_data_d;
      out_bytes_q  <= out_bytes_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_bytes = out_bytes_q;
  assign out_valid = out_valid_q;
  assign busy      = (lane_cnt_q != '0) | pop_pend_q | out_valid_q | flush_pend_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer: a small fifo model with one-cycle read latency,
// a handshake monitor, a table of pack/flush vectors and hand-written corner sequences.
module tb_fifo_word_packer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        fifo_read_enable;
  logic [7:0]  fifo_read_data;
  logic        fifo_empty;
  logic        flush = 1'b0;
  logic [31:0] out_data;
  logic [2:0]  out_bytes;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy;

  fifo_word_packer #(.DATA_WIDTH(8), .PACK_COUNT(4)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .fifo_read_enable (fifo_read_enable),
    .fifo_read_data   (fifo_read_data),
    .fifo_empty       (fifo_empty),
    .flush            (flush),
    .out_data         (out_data),
    .out_bytes        (out_bytes),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  // Upstream fifo: registered read, pops ignored while empty, cleared while in reset.
  logic [7:0] mem [256];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;
  int         pop_count = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr         <= wr_ptr;
      fifo_read_data <= 8'd0;
    end else if (fifo_read_enable && !fifo_empty) begin
      fifo_read_data <= mem[rd_ptr];
      rd_ptr         <= rd_ptr + 8'd1;
      pop_count      <= pop_count + 1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] hs_data [$];
  logic [2:0]  hs_bytes [$];
  int          hs_cyc [$];
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      hs_data.push_back(out_data);
      hs_bytes.push_back(out_bytes);
      hs_cyc.push_back(cyc);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_word(input string name, input logic [31:0] exp_d,
                           input logic [2:0] exp_b, output int hcyc);
    int n;
    n = 0;
    while (hs_data.size() == 0 && n < 60) begin
      sample();
      n++;
    end
    if (hs_data.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no word within 60 cycles, required %h", name, exp_d);
      hcyc = -1;
    end else begin
      check({name, " data"}, hs_data.pop_front(), exp_d);
      check({name, " bytes"}, {29'd0, hs_bytes.pop_front()}, {29'd0, exp_b});
      hcyc = hs_cyc.pop_front();
    end
  endtask

  typedef struct {
    logic [31:0] din;
    int          n;
    logic [31:0] exp_d;
    logic [2:0]  exp_b;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1, c2, c3, pc0;
    logic [31:0] din;

    vecs[0] = '{din: 32'h44332211, n: 4, exp_d: 32'h44332211, exp_b: 3'd4};
    vecs[1] = '{din: 32'hDEADBEEF, n: 4, exp_d: 32'hDEADBEEF, exp_b: 3'd4};
    vecs[2] = '{din: 32'h0000005A, n: 1, exp_d: 32'h0000005A, exp_b: 3'd1};
    vecs[3] = '{din: 32'h00C0FFEE, n: 3, exp_d: 32'h00C0FFEE, exp_b: 3'd3};
    vecs[4] = '{din: 32'h00001234, n: 2, exp_d: 32'h00001234, exp_b: 3'd2};
    vecs[5] = '{din: 32'h80000001, n: 4, exp_d: 32'h80000001, exp_b: 3'd4};

    // Reset state, with a non-empty fifo so the pop request must be held low by reset.
    repeat (2) tick();
    push(8'h77);
    sample();
    check("reset read_enable", {31'd0, fifo_read_enable}, 32'd0);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset out_data", out_data, 32'd0);
    check("reset out_bytes", {29'd0, out_bytes}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      din = vecs[i].din;
      for (int k = 0; k < vecs[i].n; k++) push(din[k*8 +: 8]);
      if (vecs[i].n < 4) begin
        repeat (vecs[i].n + 4) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
      end
      wait_word($sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_b, c1);
      sample();
      check($sformatf("vec%0d valid one cycle", i), {31'd0, out_valid}, 32'd0);
      repeat (2) sample();
      check($sformatf("vec%0d busy idle", i), {31'd0, busy}, 32'd0);
      tick();
    end

    // Backpressure: first word held, second assembled, ninth entry must wait.
    pc0 = pop_count;
    out_ready = 1'b0;
    for (int k = 1; k <= 9; k++) push(8'(k));
    repeat (8) sample();
    check("hold valid", {31'd0, out_valid}, 32'd1);
    check("hold data early", out_data, 32'h04030201);
    repeat (6) sample();
    check("hold data late", out_data, 32'h04030201);
    check("hold bytes", {29'd0, out_bytes}, 32'd4);
    check("hold pops", 32'(pop_count - pc0), 32'd8);
    check("hold read_enable", {31'd0, fifo_read_enable}, 32'd0);
    check("hold no handshake", 32'(hs_data.size()), 32'd0);
    tick();
    out_ready = 1'b1;
    wait_word("release w1", 32'h04030201, 3'd4, c1);
    wait_word("release w2", 32'h08070605, 3'd4, c2);
    check("release back-to-back", 32'(c2 - c1), 32'd1);
    repeat (6) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_word("ninth entry", 32'h00000009, 3'd1, c3);
    repeat (3) sample();
    check("ninth busy idle", {31'd0, busy}, 32'd0);

    // Partial word on flush after the fifo runs dry.
    tick();
    push(8'hA1); push(8'hA2); push(8'hA3);
    repeat (8) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_word("flush3", 32'h00A3A2A1, 3'd3, c1);
    repeat (3) sample();
    check("flush3 busy falls", {31'd0, busy}, 32'd0);

    // Flush in the same cycle as a pop: the in-flight entry still lands.
    tick();
    push(8'hB1);
    repeat (6) tick();
    push(8'hB2);
    flush = 1'b1;
    sample();
    check("inflight pop issued", {31'd0, fifo_read_enable}, 32'd1);
    tick();
    flush = 1'b0;
    wait_word("inflight flush", 32'h0000B2B1, 3'd2, c1);
    repeat (3) sample();
    check("inflight busy falls", {31'd0, busy}, 32'd0);

    // Flush with nothing accumulated.
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    sample();
    check("empty flush pending", {31'd0, busy}, 32'd1);
    sample();
    check("empty flush cleared", {31'd0, busy}, 32'd0);
    check("empty flush no word", {31'd0, out_valid}, 32'd0);
    check("empty flush no handshake", 32'(hs_data.size()), 32'd0);

    // Asynchronous reset mid-word with a held output word.
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) push(8'hC1 + 8'(k));
    repeat (14) sample();
    check("mid valid before reset", {31'd0, out_valid}, 32'd1);
    check("mid data before reset", out_data, 32'hC4C3C2C1);
    #1;
    reset_n = 1'b0;
    #1;
    check("async out_valid", {31'd0, out_valid}, 32'd0);
    check("async out_data", out_data, 32'd0);
    check("async out_bytes", {29'd0, out_bytes}, 32'd0);
    check("async busy", {31'd0, busy}, 32'd0);
    push(8'hEE);
    #1;
    check("async read_enable", {31'd0, fifo_read_enable}, 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    out_ready = 1'b1;
    tick();
    check("post reset no handshake", 32'(hs_data.size()), 32'd0);
    push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4);
    wait_word("post reset word", 32'hD4D3D2D1, 3'd4, c1);
    sample();
    check("post reset valid one cycle", {31'd0, out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
